bldc_hall_emulator: RTL and testbench



---
 rtl/bldc_hall_emulator.sv | 213 +++++++++++++++++++++
 tb/tb_bldc_hall_emulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_hall_emulator.sv
// -----------------------------------------------------------------------------
// bldc_hall_emulator
//
// Motor/rotor model that sits on the far side of a BLDC controller. It watches
// the six gate-drive signals the controller produces and answers with the three
// Hall sensor signals the controller expects. The rotor advances one electrical
// sector after STEP_CYCLES clocks of uninterrupted torque in one direction.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   A_IN     in   phase A high-side gate drive
//   AA_IN    in   phase A low-side gate drive
//   B_IN     in   phase B high-side gate drive
//   BB_IN    in   phase B low-side gate drive
//   C_IN     in   phase C high-side gate drive
//   CC_IN    in   phase C low-side gate drive
//   H1..H3   out  registered Hall sensor outputs, always HALL(SECTOR)
//   SECTOR   out  current rotor sector, 0..5
//   STEP     out  one-cycle pulse on each sector change
//   FAULT    out  sticky shoot-through flag, cleared only by RST
//
// Parameters:
//   STEP_CYCLES  clocks of valid torque per sector (>= 2)
//   CNT_W        step counter width (2**CNT_W > STEP_CYCLES)
//   INIT_SECTOR  sector loaded at reset (0..5)
// -----------------------------------------------------------------------------
module bldc_hall_emulator #(
  parameter int STEP_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int INIT_SECTOR = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_IN,
  input  logic       AA_IN,
  input  logic       B_IN,
  input  logic       BB_IN,
  input  logic       C_IN,
  input  logic       CC_IN,
  output logic       H1,
  output logic       H2,
  output logic       H3,
  output logic [2:0] SECTOR,
  output logic       STEP,
  output logic       FAULT
);

  localparam logic [2:0]       INIT_SEC  = 3'(INIT_SECTOR);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Relation between the commanded torque vector and the current rotor sector.
  typedef enum logic [1:0] {
    REL_HOLD = 2'd0,
    REL_FWD  = 2'd1,
    REL_REV  = 2'd2
  } rel_t;

  // Hall code {H3,H2,H1} for a rotor sector. Codes 6/7 cannot occur; they map
  // to the all-zero pattern a real sensor never produces.
  function automatic logic [2:0] hall_of(input logic [2:0] sec);
    logic [2:0] h;
    case (sec)
      3'd0:    h = 3'b001;
      3'd1:    h = 3'b101;
      3'd2:    h = 3'b100;
      3'd3:    h = 3'b110;
      3'd4:    h = 3'b010;
      3'd5:    h = 3'b011;
      default: h = 3'b000;
    endcase
    return h;
  endfunction

  // (sec + 1) mod 6
  function automatic logic [2:0] sec_inc(input logic [2:0] sec);
    logic [2:0] n;
    if (sec >= 3'd5) begin
      n = 3'd0;
    end else begin
      n = sec + 3'd1;
    end
    return n;
  endfunction

  // (sec + 5) mod 6, i.e. one sector backwards
  function automatic logic [2:0] sec_dec(input logic [2:0] sec);
    logic [2:0] n;
    if (sec == 3'd0) begin
      n = 3'd5;
    end else if (sec > 3'd5) begin
      n = 3'd5;
    end else begin
      n = sec - 3'd1;
    end
    return n;
  endfunction

  // Synchroniser stages, packed as {A, AA, B, BB, C, CC}.
  logic [5:0]       r_s1;
  logic [5:0]       r_s2;
  logic [2:0]       r_sector;
  logic [2:0]       r_hall;
  logic             r_step;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;
  rel_t             r_prev_rel;

  logic [2:0]       w_hi;
  logic [2:0]       w_lo;
  logic             w_shoot;
  logic             w_pat_ok;
  logic [2:0]       w_cmd;
  logic             w_valid;
  rel_t             w_rel;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_adv;
  logic [2:0]       w_sector_nxt;

  // High-side and low-side views of the synchronised drive, phase order A,B,C.
  assign w_hi    = {r_s2[5], r_s2[3], r_s2[1]};
  assign w_lo    = {r_s2[4], r_s2[2], r_s2[0]};
  assign w_shoot = |(w_hi & w_lo);

  // Command decode: only the six one-high/one-low cross-phase patterns are
  // legal; every other combination falls to the default and is invalid.
  always_comb begin
    w_pat_ok = 1'b0;
    w_cmd    = 3'd0;
    case ({w_hi, w_lo})
      6'b100_010: begin w_pat_ok = 1'b1; w_cmd = 3'd0; end  // A+ B-
      6'b100_001: begin w_pat_ok = 1'b1; w_cmd = 3'd1; end  // A+ C-
      6'b010_001: begin w_pat_ok = 1'b1; w_cmd = 3'd2; end  // B+ C-
      6'b010_100: begin w_pat_ok = 1'b1; w_cmd = 3'd3; end  // B+ A-
      6'b001_100: begin w_pat_ok = 1'b1; w_cmd = 3'd4; end  // C+ A-
      6'b001_010: begin w_pat_ok = 1'b1; w_cmd = 3'd5; end  // C+ B-
      default:    begin w_pat_ok = 1'b0; w_cmd = 3'd0; end
    endcase
  end

  // A latched shoot-through fault disables the rotor regardless of the drive.
  assign w_valid = w_pat_ok & ~r_fault;

  // Relation of the command to the rotor: one ahead pulls forward, one behind
  // pulls backward, anything else (aligned, opposite, invalid) holds.
  always_comb begin
    w_rel = REL_HOLD;
    if (w_valid && (w_cmd == sec_inc(r_sector))) begin
      w_rel = REL_FWD;
    end else if (w_valid && (w_cmd == sec_dec(r_sector))) begin
      w_rel = REL_REV;
    end else begin
      w_rel = REL_HOLD;
    end
  end

  // Step counter and sector advance. The count only matures while the same
  // direction was seen on the previous cycle, so a direction flip restarts it
  // and the sector can never move against the most recent torque.
  always_comb begin
    w_cnt_nxt    = '0;
    w_adv        = 1'b0;
    w_sector_nxt = r_sector;
    if (w_rel == REL_HOLD) begin
      w_cnt_nxt = '0;
    end else if (w_rel == r_prev_rel) begin
      if (r_cnt == STEP_LAST) begin
        w_cnt_nxt = '0;
        w_adv     = 1'b1;
        if (w_rel == REL_FWD) begin
          w_sector_nxt = sec_inc(r_sector);
        end else begin
          w_sector_nxt = sec_dec(r_sector);
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_nxt = CNT_ONE;
    end
  end

  // State registers; Hall code is derived from the next sector so it changes
  // on exactly the same edge as SECTOR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1       <= 6'b000000;
      r_s2       <= 6'b000000;
      r_sector   <= INIT_SEC;
      r_hall     <= hall_of(INIT_SEC);
      r_step     <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
      r_prev_rel <= REL_HOLD;
    end else begin
      r_s1       <= {A_IN, AA_IN, B_IN, BB_IN, C_IN, CC_IN};
      r_s2       <= r_s1;
      r_sector   <= w_sector_nxt;
      r_hall     <= hall_of(w_sector_nxt);
      r_step     <= w_adv;
      r_fault    <= r_fault | w_shoot;
      r_cnt      <= w_cnt_nxt;
      r_prev_rel <= w_rel;
    end
  end

  assign {H3, H2, H1} = r_hall;
  assign SECTOR       = r_sector;
  assign STEP         = r_step;
  assign FAULT        = r_fault;

endmodule

// File: tb/tb_bldc_hall_emulator.sv
// -----------------------------------------------------------------------------
// tb_bldc_hall_emulator
//
// Directed bench for bldc_hall_emulator with STEP_CYCLES=4, INIT_SECTOR=0.
// Inputs are driven 1 time unit after a rising edge ("applied before the next
// edge k"); outputs are sampled at the same point, reflecting the edge just
// taken. A drive applied before edge k produces its sector change at edge k+5.
// -----------------------------------------------------------------------------
module tb_bldc_hall_emulator;

  localparam int STEP_CYCLES = 4;

  logic       CLK;
  logic       RST;
  logic       A_IN, AA_IN, B_IN, BB_IN, C_IN, CC_IN;
  logic       H1, H2, H3;
  logic [2:0] SECTOR;
  logic       STEP;
  logic       FAULT;

  int n_chk;
  int n_err;

  bldc_hall_emulator #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (8),
    .INIT_SECTOR(0)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .A_IN  (A_IN),
    .AA_IN (AA_IN),
    .B_IN  (B_IN),
    .BB_IN (BB_IN),
    .C_IN  (C_IN),
    .CC_IN (CC_IN),
    .H1    (H1),
    .H2    (H2),
    .H3    (H3),
    .SECTOR(SECTOR),
    .STEP  (STEP),
    .FAULT (FAULT)
  );

  // 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive pattern {A, AA, B, BB, C, CC}.
  task automatic set_drive(input logic [5:0] p);
    {A_IN, AA_IN, B_IN, BB_IN, C_IN, CC_IN} = p;
  endtask

  // Gate pattern for a commutation command.
  function automatic logic [5:0] cmd_pat(input int c);
    logic [5:0] p;
    case (c)
      0:       p = 6'b100100;  // A+ B-
      1:       p = 6'b100001;  // A+ C-
      2:       p = 6'b001001;  // B+ C-
      3:       p = 6'b011000;  // B+ A-
      4:       p = 6'b010010;  // C+ A-
      5:       p = 6'b000110;  // C+ B-
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  // Reference Hall table {H3,H2,H1}.
  function automatic logic [2:0] exp_hall(input int s);
    logic [2:0] h;
    case (s)
      0:       h = 3'b001;
      1:       h = 3'b101;
      2:       h = 3'b100;
      3:       h = 3'b110;
      4:       h = 3'b010;
      5:       h = 3'b011;
      default: h = 3'b000;
    endcase
    return h;
  endfunction

  logic [5:0] hold_pats [4];
  int         cur_sec;
  int         nxt_sec;
  int         waited;
  logic       saw_step;

  initial begin
    n_chk = 0;
    n_err = 0;
    RST   = 1'b1;
    set_drive(6'b000000);

    // ---------------- reset ----------------
    tick(); tick(); tick();
    check_eq("rst_sector", SECTOR, 0);
    check_eq("rst_hall", {H3, H2, H1}, 3'b001);
    check_eq("rst_fault", FAULT, 0);
    check_eq("rst_step", STEP, 0);

    // ---------------- forward step from sector 0 (cmd 1) ----------------
    RST = 1'b0;
    set_drive(cmd_pat(1));               // before edge k
    for (int i = 0; i < 5; i++) begin    // edges k .. k+4
      tick();
      check_eq("fwd_wait_sector", SECTOR, 0);
      check_eq("fwd_wait_step", STEP, 0);
    end
    tick();                              // edge k+5
    check_eq("fwd_sector", SECTOR, 1);
    check_eq("fwd_hall", {H3, H2, H1}, 3'b101);
    check_eq("fwd_step", STEP, 1);
    tick();
    check_eq("fwd_step_single", STEP, 0);
    check_eq("fwd_sector_held", SECTOR, 1);

    // ---------------- closed-loop rotation ----------------
    // The bench commutates right after seeing STEP, so each new command lands
    // before the next edge and matures STEP_CYCLES+2 edges after the pulse.
    cur_sec = 1;
    for (int n = 0; n < 6; n++) begin
      nxt_sec = (cur_sec + 1) % 6;
      set_drive(cmd_pat(nxt_sec));
      waited = 0;
      do begin
        tick();
        waited = waited + 1;
      end while ((STEP !== 1'b1) && (waited < 20));
      check_eq("loop_interval", waited, STEP_CYCLES + 2);
      check_eq("loop_sector", SECTOR, nxt_sec);
      check_eq("loop_hall", {H3, H2, H1}, exp_hall(nxt_sec));
      cur_sec = nxt_sec;
    end

    // ---------------- reverse from sector 0 (cmd 5) ----------------
    set_drive(6'b000000);
    RST = 1'b1;
    tick();
    check_eq("rst2_sector", SECTOR, 0);
    RST = 1'b0;
    set_drive(cmd_pat(5));
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rev_wait_sector", SECTOR, 0);
    end
    tick();
    check_eq("rev_sector", SECTOR, 5);
    check_eq("rev_hall", {H3, H2, H1}, 3'b011);
    check_eq("rev_step", STEP, 1);

    // ---------------- hold patterns at sector 5 ----------------
    hold_pats[0] = cmd_pat(5);           // aligned
    hold_pats[1] = cmd_pat(2);           // opposite
    hold_pats[2] = 6'b000000;            // all off
    hold_pats[3] = 6'b101001;            // two high sides
    for (int p = 0; p < 4; p++) begin
      set_drive(hold_pats[p]);
      saw_step = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (STEP === 1'b1) begin
          saw_step = 1'b1;
        end
      end
      check_eq("hold_sector", SECTOR, 5);
      check_eq("hold_no_step", saw_step, 0);
    end

    // forward wrap 5 -> 0 starting from a cleared counter
    set_drive(cmd_pat(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wrap_wait_sector", SECTOR, 5);
    end
    tick();
    check_eq("wrap_sector", SECTOR, 0);
    check_eq("wrap_hall", {H3, H2, H1}, 3'b001);

    // ---------------- direction change mid-step ----------------
    // FWD in s2 for two cycles, then REV reaches s2; sector moves back 4 edges
    // later and never forward.
    set_drive(cmd_pat(1));
    tick();
    tick();
    set_drive(cmd_pat(5));
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("dir_wait_sector", SECTOR, 0);
    end
    tick();
    check_eq("dir_sector", SECTOR, 5);
    check_eq("dir_step", STEP, 1);

    // ---------------- shoot-through fault ----------------
    set_drive(6'b110000);                // A+ and A- together
    tick();
    set_drive(cmd_pat(0));               // valid forward drive afterwards
    check_eq("fault_early1", FAULT, 0);
    tick();
    check_eq("fault_early2", FAULT, 0);
    tick();
    check_eq("fault_set", FAULT, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    check_eq("fault_frozen_sector", SECTOR, 5);
    check_eq("fault_sticky", FAULT, 1);

    RST = 1'b1;
    tick();
    check_eq("fault_rst_fault", FAULT, 0);
    check_eq("fault_rst_sector", SECTOR, 0);
    check_eq("fault_rst_hall", {H3, H2, H1}, 3'b001);
    RST = 1'b0;

    // ---------------- reset mid-count ----------------
    set_drive(cmd_pat(1));
    for (int i = 0; i < 4; i++) begin    // counter reaches 2
      tick();
    end
    check_eq("mid_sector_before", SECTOR, 0);
    RST = 1'b1;
    tick();
    check_eq("mid_rst_sector", SECTOR, 0);
    check_eq("mid_rst_step", STEP, 0);
    check_eq("mid_rst_fault", FAULT, 0);
    RST = 1'b0;                          // drive still cmd 1
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mid_wait_sector", SECTOR, 0);
    end
    tick();
    check_eq("mid_sector", SECTOR, 1);
    check_eq("mid_hall", {H3, H2, H1}, 3'b101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
